// File: rtl/arb2_pkg.sv
// arb2_pkg: shared types and constants for the two-requester bus arbiter.
// Holds the FSM state encoding, owner indices and beat counter width.
package arb2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb2_state_t;

    localparam logic OWNER_0 = 1'b0;
    localparam logic OWNER_1 = 1'b1;

    localparam int CNT_W = 8;

endpackage

// File: rtl/arb2_bus_ctrl_if.sv
// arb2_bus_ctrl_if: requester, downstream and status signals of the arbiter.
// slave = arbiter view, master = view of the masters/consumer around it.
interface arb2_bus_ctrl_if;

    logic        req0_valid;
    logic [31:0] req0_data;
    logic        req0_last;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_data;
    logic        req1_last;
    logic        req1_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic [1:0]  grant;
    logic        busy;

    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_data, out_last,
        output grant, busy
    );

    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_data, out_last,
        input  grant, busy
    );

endinterface

// File: rtl/bit32_2to1mux.sv
// bit32_2to1mux: 32-bit 2:1 multiplexer.
// Ports: in0_i, in1_i data; sel_i select (1 = in1_i); out_o result.
module bit32_2to1mux (
    input  logic [31:0] in0_i,
    input  logic [31:0] in1_i,
    input  logic        sel_i,
    output logic [31:0] out_o
);

    assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/mux2to1.sv
// mux2to1: single-bit 2:1 multiplexer.
// Ports: in0_i, in1_i data; sel_i select (1 = in1_i); out_o result.
module mux2to1 (
    input  logic in0_i,
    input  logic in1_i,
    input  logic sel_i,
    output logic out_o
);

    assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/arb2_bus_ctrl.sv
// arb2_bus_ctrl: round-robin arbiter sharing one 32-bit bus between two
// burst masters. Ports: clk, rst_n (async, active low), bus (slave modport:
// req0/req1 valid/data/last/ready, out valid/data/last/ready, grant, busy).
// Optional macro ARB2_BURST_LIMIT_EN splits bursts after BURST_MAX beats.
module arb2_bus_ctrl
    import arb2_pkg::*;
#(
    parameter int BURST_MAX = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    arb2_bus_ctrl_if.slave        bus
);

    if (BURST_MAX < 2 || BURST_MAX > (1 << CNT_W)) begin : g_bad_burst_max
        $error("arb2_bus_ctrl: BURST_MAX out of range 2..256");
    end

    arb2_state_t state_q, state_d;
    logic        last_owner_q, last_owner_d;

    logic        busy;
    logic        sel;
    logic        accept;
    logic        other_valid;
    logic        limit_hit;
    logic        release_own;
    logic        mux_valid;
    logic        mux_last;
    logic [31:0] mux_data;

    assign busy = (state_q != IDLE);
    assign sel  = state_q[1];

    bit32_2to1mux u_data_mux (
        .in0_i (bus.req0_data),
        .in1_i (bus.req1_data),
        .sel_i (sel),
        .out_o (mux_data)
    );

    mux2to1 u_valid_mux (
        .in0_i (bus.req0_valid),
        .in1_i (bus.req1_valid),
        .sel_i (sel),
        .out_o (mux_valid)
    );

    mux2to1 u_last_mux (
        .in0_i (bus.req0_last),
        .in1_i (bus.req1_last),
        .sel_i (sel),
        .out_o (mux_last)
    );

    // Gate with busy so IDLE presents an all-zero bus.
    assign bus.out_valid  = mux_valid & busy;
    assign bus.out_last   = mux_last & busy;
    assign bus.out_data   = mux_data & {32{busy}};
    assign bus.grant      = state_q;
    assign bus.busy       = busy;
    assign bus.req0_ready = (state_q == OWN0) & bus.out_ready;
    assign bus.req1_ready = (state_q == OWN1) & bus.out_ready;

    assign accept      = bus.out_valid & bus.out_ready;
    assign other_valid = sel ? bus.req0_valid : bus.req1_valid;

`ifdef ARB2_BURST_LIMIT_EN
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BURST_MAX - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating at CNT_TOP keeps every later beat eligible for a split.
    assign limit_hit = (cnt_q == CNT_TOP);

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (accept && !limit_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign limit_hit = 1'b0;
`endif

    // A split only happens when someone is waiting; otherwise the owner keeps going.
    assign release_own = accept &
                         (bus.out_last | (limit_hit & other_valid));

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    state_d = (last_owner_q == OWNER_1) ? OWN0 : OWN1;
                end else if (bus.req0_valid) begin
                    state_d = OWN0;
                end else if (bus.req1_valid) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (release_own) begin
                    last_owner_d = sel;
                    if (other_valid) begin
                        state_d = sel ? OWN0 : OWN1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: tb/tb_arb2_bus_ctrl.sv
// tb_arb2_bus_ctrl: directed self-checking bench for arb2_bus_ctrl.
// Built with BURST_MAX = 4; honours ARB2_BURST_LIMIT_EN if defined.
module tb_arb2_bus_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    arb2_bus_ctrl_if bus ();

    arb2_bus_ctrl #(
        .BURST_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req0_data  = 32'h0;
        bus.req0_last  = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req1_data  = 32'h0;
        bus.req1_last  = 1'b0;
        bus.out_ready  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 32'hFFFF_FFFF;
        bus.req0_last  = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 32'hFFFF_FFFF;
        bus.req1_last  = 1'b1;
        bus.out_ready  = 1'b1;
        #3;
        n_checks++;
        if (bus.grant !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_grant got %b want 00", bus.grant);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        n_checks++;
        if (bus.out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out_data got %h want 0", bus.out_data);
        end
        n_checks++;
        if (bus.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_last got %b want 0", bus.out_last);
        end
        n_checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready got %b%b want 00",
                     bus.req0_ready, bus.req1_ready);
        end
        step();
        step();
        n_checks++;
        if (bus.grant !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_held_grant got %b want 00", bus.grant);
        end
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single_beat();
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 32'hDEAD_BEEF;
        bus.req0_last  = 1'b1;
        bus.out_ready  = 1'b1;
        #2;
        n_checks++;
        if (bus.grant !== 2'b00) begin
            n_fail++;
            $display("FAIL single_pre_grant got %b want 00", bus.grant);
        end
        step();
        #2;
        n_checks++;
        if (bus.grant !== 2'b01) begin
            n_fail++;
            $display("FAIL single_grant got %b want 01", bus.grant);
        end
        n_checks++;
        if (bus.out_data !== 32'hDEAD_BEEF || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_data got %h/%b want deadbeef/1",
                     bus.out_data, bus.out_valid);
        end
        n_checks++;
        if (bus.req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready got %b want 1", bus.req0_ready);
        end
        step();
        bus.req0_valid = 1'b0;
        #2;
        n_checks++;
        if (bus.grant !== 2'b00 || bus.req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release got %b/%b want 00/0",
                     bus.grant, bus.req0_ready);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 32'h11;
        bus.req0_last  = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 32'h22;
        bus.req1_last  = 1'b1;
        bus.out_ready  = 1'b1;
        step();
        #2;
        n_checks++;
        if (bus.grant !== 2'b01 || bus.out_data !== 32'h11) begin
            n_fail++;
            $display("FAIL tie_first got %b/%h want 01/11",
                     bus.grant, bus.out_data);
        end
        step();
        bus.req0_valid = 1'b0;
        #2;
        n_checks++;
        if (bus.grant !== 2'b10 || bus.out_data !== 32'h22) begin
            n_fail++;
            $display("FAIL tie_second got %b/%h want 10/22",
                     bus.grant, bus.out_data);
        end
        n_checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_ready got %b%b want 01",
                     bus.req0_ready, bus.req1_ready);
        end
        step();
        bus.req1_valid = 1'b0;
        #2;
        n_checks++;
        if (bus.grant !== 2'b00) begin
            n_fail++;
            $display("FAIL tie_idle got %b want 00", bus.grant);
        end
    endtask

    task automatic test_burst_stall();
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 32'h1;
        bus.req0_last  = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 32'hAA;
        bus.req1_last  = 1'b1;
        bus.out_ready  = 1'b1;
        step();
        #2;
        n_checks++;
        if (bus.grant !== 2'b01 || bus.out_data !== 32'h1) begin
            n_fail++;
            $display("FAIL stall_beat1 got %b/%h want 01/1",
                     bus.grant, bus.out_data);
        end
        step();
        bus.req0_data = 32'h2;
        #2;
        n_checks++;
        if (bus.grant !== 2'b01 || bus.out_data !== 32'h2) begin
            n_fail++;
            $display("FAIL stall_beat2 got %b/%h want 01/2",
                     bus.grant, bus.out_data);
        end
        step();
        bus.req0_data = 32'h3;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            n_checks++;
            if (bus.grant !== 2'b01 || bus.out_data !== 32'h3 ||
                bus.req0_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d got %b/%h/%b want 01/3/0",
                         i, bus.grant, bus.out_data, bus.req0_ready);
            end
            step();
        end
        bus.out_ready = 1'b1;
        #2;
        n_checks++;
        if (bus.out_data !== 32'h3 || bus.req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_resume got %h/%b want 3/1",
                     bus.out_data, bus.req0_ready);
        end
        step();
        bus.req0_data = 32'h4;
        bus.req0_last = 1'b1;
        #2;
        n_checks++;
        if (bus.grant !== 2'b01 || bus.out_data !== 32'h4) begin
            n_fail++;
            $display("FAIL stall_beat4 got %b/%h want 01/4",
                     bus.grant, bus.out_data);
        end
        step();
        bus.req0_valid = 1'b0;
        #2;
        n_checks++;
        if (bus.grant !== 2'b10 || bus.out_data !== 32'hAA) begin
            n_fail++;
            $display("FAIL stall_handoff got %b/%h want 10/aa",
                     bus.grant, bus.out_data);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_g;
        logic [31:0] exp_d;
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 32'hA0;
        bus.req0_last  = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 32'hB0;
        bus.req1_last  = 1'b1;
        bus.out_ready  = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (i % 2 == 0) ? 32'hA0 : 32'hB0;
            #2;
            n_checks++;
            if (bus.grant !== exp_g || bus.out_data !== exp_d) begin
                n_fail++;
                $display("FAIL rr_beat%0d got %b/%h want %b/%h",
                         i, bus.grant, bus.out_data, exp_g, exp_d);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_burst_limit();
        int nbeats;
`ifdef ARB2_BURST_LIMIT_EN
        nbeats = 4;
`else
        nbeats = 10;
`endif
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 32'h1;
        bus.req0_last  = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_data  = 32'h55;
        bus.req1_last  = 1'b1;
        bus.out_ready  = 1'b1;
        step();
        for (int i = 1; i <= nbeats; i++) begin
            bus.req0_data = 32'(i);
            bus.req0_last = (i == 10);
            #2;
            n_checks++;
            if (bus.grant !== 2'b01 || bus.out_data !== 32'(i)) begin
                n_fail++;
                $display("FAIL limit_beat%0d got %b/%h want 01/%h",
                         i, bus.grant, bus.out_data, 32'(i));
            end
            step();
        end
        bus.req0_data = 32'(nbeats + 1);
        bus.req0_last = 1'b0;
        #2;
        n_checks++;
        if (bus.grant !== 2'b10 || bus.out_data !== 32'h55 ||
            bus.req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL limit_handoff got %b/%h/%b want 10/55/0",
                     bus.grant, bus.out_data, bus.req0_ready);
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 32'h77;
        bus.req0_last  = 1'b1;
        bus.out_ready  = 1'b1;
        step();
        step();
        bus.req0_data = 32'h1;
        bus.req0_last = 1'b0;
        #2;
        n_checks++;
        if (bus.grant !== 2'b00) begin
            n_fail++;
            $display("FAIL arst_gap got %b want 00", bus.grant);
        end
        step();
        step();
        bus.req0_data = 32'h2;
        #2;
        n_checks++;
        if (bus.grant !== 2'b01 || bus.out_data !== 32'h2) begin
            n_fail++;
            $display("FAIL arst_beat2 got %b/%h want 01/2",
                     bus.grant, bus.out_data);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.grant !== 2'b00 || bus.out_valid !== 1'b0 ||
            bus.req0_ready !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_drop got %b/%b/%b/%b want 00/0/0/0",
                     bus.grant, bus.out_valid, bus.req0_ready, bus.busy);
        end
        bus.req1_valid = 1'b1;
        bus.req1_data  = 32'h99;
        bus.req1_last  = 1'b1;
        step();
        rst_n = 1'b1;
        #2;
        n_checks++;
        if (bus.grant !== 2'b00) begin
            n_fail++;
            $display("FAIL arst_release got %b want 00", bus.grant);
        end
        step();
        #2;
        n_checks++;
        if (bus.grant !== 2'b01 || bus.out_data !== 32'h2) begin
            n_fail++;
            $display("FAIL arst_first got %b/%h want 01/2",
                     bus.grant, bus.out_data);
        end
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        test_reset();
        test_single_beat();
        test_simultaneous();
        test_burst_stall();
        test_round_robin();
        test_burst_limit();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
